// File: rtl/conf_merge_pkg.sv
// Shared types and helpers for the N-way drive/free merge: FSM state encoding,
// arbitration mode constants and one-hot to index conversion.
package conf_merge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FREE = 2'd2
    } state_t;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;
    localparam int MAX_N      = 16;

    // OR-reduction of set positions; exact for a one-hot (or zero) vector.
    function automatic logic [3:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < MAX_N; i++) begin
            if (oh[i]) begin
                idx = idx | 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/conf_merge_if.sv
// Bundle of the N upstream drive/free channels and the single downstream
// drive/free channel of the merge.
interface conf_merge_if #(
    parameter int N      = 4,
    parameter int DATA_W = 32,
    parameter int ID_W   = $clog2(N)
);
    logic [N-1:0]        i_drive;
    logic [N*DATA_W-1:0] i_data;
    logic [N-1:0]        o_free;
    logic                o_driveNext;
    logic [DATA_W-1:0]   o_data;
    logic [ID_W-1:0]     o_id;
    logic                i_freeNext;
    logic                o_err;

    modport master (
        output i_drive,
        output i_data,
        output i_freeNext,
        input  o_free,
        input  o_driveNext,
        input  o_data,
        input  o_id,
        input  o_err
    );

    modport slave (
        input  i_drive,
        input  i_data,
        input  i_freeNext,
        output o_free,
        output o_driveNext,
        output o_data,
        output o_id,
        output o_err
    );
endinterface

// File: rtl/conf_rr_arb.sv
// N-way request arbiter, fixed priority (lowest index wins) or round-robin
// starting at a pointer that moves past each accepted winner.
module conf_rr_arb
    import conf_merge_pkg::*;
#(
    parameter int N    = 4,
    parameter int MODE = MODE_RR,
    parameter int ID_W = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            en,
    input  logic [N-1:0]    mask,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_idx,
    output logic            valid
);

    logic [ID_W-1:0] ptr_r;
    logic [ID_W-1:0] ptr_nxt_s;
    logic [N-1:0]    eff_s;
    logic [N-1:0]    gnt_s;
    logic [ID_W-1:0] idx_s;
    logic            valid_s;

    // rotating search from the pointer; the first unmasked request wins
    always_comb begin
        int k;
        k     = 0;
        eff_s = req & ~mask;
        gnt_s = '0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr_r) + i;
            if (k >= N) begin
                k = k - N;
            end else begin
                k = k;
            end
            if ((gnt_s == '0) && eff_s[k]) begin
                gnt_s[k] = 1'b1;
            end else begin
                gnt_s = gnt_s;
            end
        end
        valid_s = |gnt_s;
        idx_s   = ID_W'(onehot_to_idx(16'(gnt_s)));
    end

    // pointer moves only when a grant is actually taken
    always_comb begin
        ptr_nxt_s = ptr_r;
        if ((MODE == MODE_RR) && en && valid_s) begin
            if (idx_s == ID_W'(N - 1)) begin
                ptr_nxt_s = '0;
            end else begin
                ptr_nxt_s = idx_s + ID_W'(1);
            end
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end

    // round-robin pointer register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_r <= '0;
        end else begin
            ptr_r <= ptr_nxt_s;
        end
    end

    assign gnt     = gnt_s;
    assign gnt_idx = idx_s;
    assign valid   = valid_s;

endmodule

// File: rtl/conf_merge_n.sv
// Clocked N-to-1 drive/free merge: arbitrates upstream requests, registers the
// winner's payload and index downstream, and routes the downstream free back.
module conf_merge_n
    import conf_merge_pkg::*;
#(
    parameter int N      = 4,
    parameter int DATA_W = 32,
    parameter int MODE   = MODE_RR,
    parameter int ID_W   = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    conf_merge_if.slave  bus
);

    state_t            state_r;
    state_t            state_nxt_s;

    logic [N-1:0]      arb_gnt_s;
    logic [ID_W-1:0]   arb_idx_s;
    logic              arb_valid_s;
    logic              arb_en_s;
    logic [N-1:0]      arb_mask_s;
    logic [DATA_W-1:0] arb_data_s;
    logic [N-1:0]      id_oh_s;

    logic              drive_nxt_s;
    logic [N-1:0]      free_nxt_s;
    logic [DATA_W-1:0] data_nxt_s;
    logic [ID_W-1:0]   id_nxt_s;
    logic              err_nxt_s;

    logic              drive_r;
    logic [N-1:0]      free_r;
    logic [DATA_W-1:0] data_r;
    logic [ID_W-1:0]   id_r;
    logic              err_r;

    assign id_oh_s = {{(N-1){1'b0}}, 1'b1} << id_r;

    // the arbiter only commits in IDLE; the freed source is hidden while in FREE
    assign arb_en_s   = (state_r == IDLE);
    assign arb_mask_s = (state_r == FREE) ? id_oh_s : {N{1'b0}};

    conf_rr_arb #(
        .N    (N),
        .MODE (MODE),
        .ID_W (ID_W)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.i_drive),
        .en      (arb_en_s),
        .mask    (arb_mask_s),
        .gnt     (arb_gnt_s),
        .gnt_idx (arb_idx_s),
        .valid   (arb_valid_s)
    );

    // payload of the winning channel via one-hot AND-OR mux
    always_comb begin
        arb_data_s = '0;
        for (int k = 0; k < N; k++) begin
            if (arb_gnt_s[k]) begin
                arb_data_s = arb_data_s | bus.i_data[k*DATA_W +: DATA_W];
            end else begin
                arb_data_s = arb_data_s;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (arb_valid_s) begin
                    state_nxt_s = BUSY;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (bus.i_freeNext) begin
                    state_nxt_s = FREE;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            FREE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM output logic: next values for the registered outputs
    always_comb begin
        drive_nxt_s = drive_r;
        free_nxt_s  = '0;
        data_nxt_s  = data_r;
        id_nxt_s    = id_r;
        err_nxt_s   = err_r;
        case (state_r)
            IDLE: begin
                if (arb_valid_s) begin
                    drive_nxt_s = 1'b1;
                    data_nxt_s  = arb_data_s;
                    id_nxt_s    = arb_idx_s;
                end else begin
                    drive_nxt_s = drive_r;
                end
                if (bus.i_freeNext) begin
                    err_nxt_s = 1'b1;
                end else begin
                    err_nxt_s = err_r;
                end
            end
            BUSY: begin
                if (bus.i_freeNext) begin
                    drive_nxt_s = 1'b0;
                    free_nxt_s  = id_oh_s;
                end else begin
                    drive_nxt_s = drive_r;
                end
            end
            FREE: begin
                if (bus.i_freeNext) begin
                    err_nxt_s = 1'b1;
                end else begin
                    err_nxt_s = err_r;
                end
            end
            default: begin
                drive_nxt_s = 1'b0;
            end
        endcase
    end

    // output registers; reset clears everything, so no free pulse escapes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drive_r <= 1'b0;
            free_r  <= '0;
            data_r  <= '0;
            id_r    <= '0;
            err_r   <= 1'b0;
        end else begin
            drive_r <= drive_nxt_s;
            free_r  <= free_nxt_s;
            data_r  <= data_nxt_s;
            id_r    <= id_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    assign bus.o_driveNext = drive_r;
    assign bus.o_free      = free_r;
    assign bus.o_data      = data_r;
    assign bus.o_id        = id_r;
    assign bus.o_err       = err_r;

endmodule

// File: tb/tb_conf_merge_n.sv
// Bench for conf_merge_n: a fixed-priority and a round-robin instance, each
// with reactive sources/sink, a transaction-level model and a scoreboard.
module tb_conf_merge_n;

    localparam int N  = 4;
    localparam int DW = 32;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rand_en = 1'b0;
    logic       spur = 1'b0;
    logic [3:0] raise = 4'b0000;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %0h, expected %0h", nm, inst, act, exp);
        end
    endtask

    // first requesting channel found scanning upward from base, modulo N
    function automatic int pick(input logic [3:0] r, input int base);
        for (int i = 0; i < N; i++) begin
            if (r[(base + i) % N]) return (base + i) % N;
        end
        return 0;
    endfunction

    for (genvar m = 0; m < 2; m++) begin : g_inst
        conf_merge_if #(.N(N), .DATA_W(DW)) bus ();
        conf_merge_n #(.N(N), .DATA_W(DW), .MODE(m)) dut (.clk(clk), .rst(rst), .bus(bus));

        logic [3:0]      drv;
        logic [N*DW-1:0] dat;
        logic            fn;
        int              fwait;
        assign bus.i_drive    = drv;
        assign bus.i_data     = dat;
        assign bus.i_freeNext = fn;

        // sources raise levels and drop them on their free pulse; sink frees after a random delay
        initial begin
            drv = '0; dat = '0; fn = 1'b0; fwait = 0;
            forever begin
                @(negedge clk);
                for (int k = 0; k < N; k++) begin
                    if (drv[k] && bus.o_free[k]) begin
                        drv[k] = 1'b0;
                    end else if (!drv[k] && (raise[k] || (rand_en && $urandom_range(0, 5) == 0))) begin
                        drv[k] = 1'b1;
                        dat[k*DW +: DW] = raise[k] ? (32'hA5A5_0000 | 32'(k)) : $urandom;
                    end
                end
                if (fn) fn = 1'b0;
                else if (spur && !bus.o_driveNext) fn = 1'b1;
                else if (bus.o_driveNext) begin
                    if (fwait > 0) fwait--;
                    else begin
                        fn = 1'b1;
                        fwait = $urandom_range(0, 3);
                    end
                end
            end
        end

        int          ph, cur, ptr;
        logic        err_m, exp_drv;
        logic [3:0]  exp_free;
        logic [35:0] q[$];

        // reference model: one transfer at a time, grant chosen by the arbitration rule
        initial begin
            ph = 0; cur = 0; ptr = 0; err_m = 1'b0; exp_drv = 1'b0; exp_free = '0;
            forever begin
                @(posedge clk);
                if (!rst) begin
                    ph = 0; ptr = 0; err_m = 1'b0; exp_drv = 1'b0; exp_free = '0;
                    q.delete();
                end else begin
                    exp_free = '0;
                    if (ph == 0) begin
                        if (fn) err_m = 1'b1;
                        if (drv != 0) begin
                            cur = pick(drv, (m == 1) ? ptr : 0);
                            if (m == 1) ptr = (cur + 1) % N;
                            q.push_back({4'(cur), dat[cur*DW +: DW]});
                            ph = 1;
                        end
                    end else if (ph == 1) begin
                        if (fn) begin
                            ph = 2;
                            exp_free = 4'b0001 << cur;
                        end
                    end else begin
                        if (fn) err_m = 1'b1;
                        ph = 0;
                    end
                    exp_drv = (ph == 1);
                end
            end
        end

        logic        prev;
        logic [35:0] item;

        // monitor: per-cycle handshake checks, and id/data popped on each new drive
        initial begin
            prev = 1'b0;
            forever begin
                @(negedge clk);
                if (!rst) begin
                    chk("rst_drive", m, 64'(bus.o_driveNext), 64'(0));
                    chk("rst_free", m, 64'(bus.o_free), 64'(0));
                    chk("rst_err", m, 64'(bus.o_err), 64'(0));
                    chk("rst_id", m, 64'(bus.o_id), 64'(0));
                    prev = 1'b0;
                end else begin
                    chk("drive", m, 64'(bus.o_driveNext), 64'(exp_drv));
                    chk("free", m, 64'(bus.o_free), 64'(exp_free));
                    chk("err", m, 64'(bus.o_err), 64'(err_m));
                    if (bus.o_driveNext && !prev) begin
                        if (q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_grant inst%0d: id %0d with no pending expectation", m, bus.o_id);
                        end else begin
                            item = q.pop_front();
                            chk("id", m, 64'(bus.o_id), 64'(item[35:32]));
                            chk("data", m, 64'(bus.o_data), 64'(item[31:0]));
                        end
                    end
                    prev = bus.o_driveNext;
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 300 && (g_inst[0].drv != 0 || g_inst[1].drv != 0 ||
                           g_inst[0].bus.o_driveNext || g_inst[1].bus.o_driveNext ||
                           g_inst[0].bus.o_free != 0 || g_inst[1].bus.o_free != 0)) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL idle_timeout: still busy after %0d cycles, expected idle", n);
        end
    endtask

    task automatic pulse_raise(input logic [3:0] v);
        @(posedge clk); #1;
        raise = v;
        @(posedge clk); #1;
        raise = 4'b0000;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        #2 rst = 1'b0;
        cycles(3);
        rst = 1'b1;
        cycles(2);

        pulse_raise(4'b0100);
        wait_idle();
        pulse_raise(4'b1110);
        wait_idle();
        pulse_raise(4'b1111);
        wait_idle();

        cycles(2);
        spur = 1'b1;
        @(posedge clk); #1;
        spur = 1'b0;
        cycles(3);
        chk("err_set", 0, 64'(g_inst[0].bus.o_err), 64'(1));
        chk("err_set", 1, 64'(g_inst[1].bus.o_err), 64'(1));
        pulse_raise(4'b0001);
        wait_idle();
        chk("err_sticky", 0, 64'(g_inst[0].bus.o_err), 64'(1));
        chk("err_sticky", 1, 64'(g_inst[1].bus.o_err), 64'(1));

        rand_en = 1'b1;
        cycles(2000);

        n = 0;
        while (n < 100 && !g_inst[0].bus.o_driveNext) begin
            @(posedge clk); #1;
            n++;
        end
        chk("busy_before_reset", 0, 64'(g_inst[0].bus.o_driveNext), 64'(1));
        #2 rst = 1'b0;
        #1;
        chk("async_drive", 0, 64'(g_inst[0].bus.o_driveNext), 64'(0));
        chk("async_free", 0, 64'(g_inst[0].bus.o_free), 64'(0));
        chk("async_data", 0, 64'(g_inst[0].bus.o_data), 64'(0));
        chk("async_id", 0, 64'(g_inst[0].bus.o_id), 64'(0));
        chk("async_err", 0, 64'(g_inst[0].bus.o_err), 64'(0));
        chk("async_drive", 1, 64'(g_inst[1].bus.o_driveNext), 64'(0));
        chk("async_data", 1, 64'(g_inst[1].bus.o_data), 64'(0));
        chk("async_err", 1, 64'(g_inst[1].bus.o_err), 64'(0));
        cycles(2);
        rst = 1'b1;

        cycles(500);
        rand_en = 1'b0;
        wait_idle();
        cycles(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conf_merge_n.md
Name: conf_merge_n

Overview:
- Clocked, parametrised successor of the fixed 4-way control-only mutex merge.
- Merges N drive/free channels, each carrying DATA_W data, into one downstream drive/free channel.
- Arbitrates simultaneous requests by fixed priority or round-robin. Registers the winning data, tags it with its channel index, and returns downstream free only to the granted source.
- Sits in the fpga_control fabric between N producer stages and one shared consumer stage.

Parameters:
- N, 4, number of input channels (2..16).
- DATA_W, 32, payload width per channel; 0 is not allowed.
- MODE, 1, arbitration: 0 = fixed priority (channel 0 highest), 1 = round-robin.
- ID_W, $clog2(N), width of the channel-index tag.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_drive  in  N  per-channel request level; bit k held high from request until o_free[k] pulses.
- i_data  in  N*DATA_W  per-channel payload; channel k occupies bits [k*DATA_W +: DATA_W]; stable while i_drive[k]=1.
- o_free  out  N  per-channel one-cycle release pulse.
- o_driveNext  out  1  downstream request level.
- o_data  out  DATA_W  registered payload of the granted channel.
- o_id  out  ID_W  index of the granted channel.
- i_freeNext  in  1  downstream one-cycle release pulse.
- o_err  out  1  sticky flag: spurious i_freeNext.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; o_driveNext=0, o_free=0, o_data=0, o_id=0, o_err=0.
  - Round-robin pointer resets to 0, so channel 0 has first priority.
- FSM states: IDLE, BUSY, FREE.
- IDLE, with any i_drive bit set at edge t:
  - Arbiter picks grant g.
  - o_data and o_id latch i_data[g] and g; o_driveNext=1 from t+1; state goes to BUSY.
  - Request-to-drive latency is 1 cycle.
- IDLE, with no request: stay in IDLE, all outputs hold.
- BUSY:
  - o_driveNext, o_data and o_id hold until i_freeNext=1 at edge u.
  - At u+1: state=FREE, o_driveNext=0, o_free[g]=1 for exactly one cycle.
  - Downstream-free-to-source-free latency is 1 cycle.
- FREE: always returns to IDLE on the next edge. Source g must drop i_drive[g] by then.
  - Channel g is masked during FREE and ignored.
  - Channel g is re-sampled from IDLE onward.
- Throughput: minimum 3 cycles per transfer (IDLE, BUSY, FREE), with i_freeNext in the first BUSY cycle.
- Fixed priority (MODE=0): the lowest set index wins.
- Round-robin (MODE=1):
  - Search starts at ptr and wraps modulo N.
  - On each grant, ptr becomes (g+1) mod N, so ptr wraps from N-1 to 0.
  - ptr does not change in cycles without a grant.
- A request that arrives while BUSY or FREE waits; it is not lost because drive is a level.
- Requests that drop before being granted are simply not served.
- Spurious free: i_freeNext=1 in IDLE or FREE sets o_err=1. Only reset clears o_err. State is unaffected.
- Reset mid-transfer: all outputs clear at once and no o_free pulse is issued. Sources re-request after reset.
- At most one bit of o_free is ever high (one-hot or zero).

Decomposition:
- conf_merge_pkg:
  - state enum {IDLE, BUSY, FREE}.
  - MODE_FIXED=0 and MODE_RR=1 constants.
  - Function for the one-hot to index conversion.
- Sub-module conf_rr_arb:
  - Parametrised by N and MODE.
  - Inputs: request vector, enable, mask.
  - Outputs: one-hot grant, grant index, valid.
  - Holds the round-robin pointer, which advances on enable&&valid.

Test Plan:
- Single request: N=4, channel 2 drives 0xA5A5_0002 at t → o_driveNext=1, o_data=0xA5A5_0002, o_id=2 at t+1. i_freeNext at t+3 → o_free=4'b0100 at t+4 only.
- Simultaneous request, MODE=0: i_drive=4'b1110 held → grants come out in the order 1, 2, 3.
- Simultaneous request, MODE=1: i_drive=4'b1111 held, each source re-raising after its free → o_id sequence 0, 1, 2, 3, 0. This checks the pointer wrap.
- Round-robin fairness: channel 0 is always requesting while channel 3 requests once → channel 3 is granted within N transfers.
- Spurious free: i_freeNext pulse in IDLE → o_err=1 and it stays 1. A following normal transfer still completes.
- Reset mid-BUSY: rst=0 while o_driveNext=1 → all outputs 0 asynchronously, no o_free pulse. After release, a pending request is granted from channel 0 priority.
